column_approx_mult_pipe: RTL



---
 rtl/col_approx_pkg.sv | 16 +
 rtl/column_approx_row.sv | 25 ++
 rtl/column_approx_mult_pipe.sv | 90 +++++++++
 3 files changed

// File: rtl/col_approx_pkg.sv
// Shared constants and helpers for the column-truncation approximate multiplier.
package col_approx_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefTw    = 4;

  function automatic int unsigned clamp_theta(int unsigned theta, int unsigned width);
    return (theta > width) ? width : theta;
  endfunction

  // Number of low bits of x dropped in row i for effective theta te.
  function automatic int unsigned row_shift(int unsigned i, int unsigned te);
    return (te > i) ? te - i : 0;
  endfunction

endpackage

// File: rtl/column_approx_row.sv
// One partial-product row: x truncated by row_shift, gated by y_bit, shifted by ROW.
module column_approx_row
  import col_approx_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned TW    = DefTw,
  parameter int unsigned ROW   = 0
) (
  input  logic [WIDTH-1:0]   x_i,
  input  logic               y_bit_i,
  input  logic [TW-1:0]      te_i,
  output logic [2*WIDTH-1:0] row_o
);

  logic [WIDTH-1:0]   mask;
  logic [2*WIDTH-1:0] row_ext;

  always_comb begin
    // A shift of WIDTH or more clears the whole mask, dropping the row entirely.
    mask    = {WIDTH{1'b1}} << row_shift(ROW, 32'(te_i));
    row_ext = {{WIDTH{1'b0}}, x_i & mask & {WIDTH{y_bit_i}}};
    row_o   = row_ext << ROW;
  end

endmodule

// File: rtl/column_approx_mult_pipe.sv
// Two-stage pipelined column-truncation approximate multiplier with runtime theta.
module column_approx_mult_pipe
  import col_approx_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned TW    = DefTw,
  parameter int unsigned SPLIT = WIDTH / 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [TW-1:0]      theta,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z,
  output logic [TW-1:0]      z_theta
);

  logic [TW-1:0]      te_in;
  logic [2*WIDTH-1:0] rows [WIDTH];
  logic [2*WIDTH-1:0] sum_a, sum_b;

  logic               s1_valid_q, s2_valid_q;
  logic [2*WIDTH-1:0] a_q, b_q, z_q;
  logic [TW-1:0]      te_q, z_theta_q;
  logic               s1_adv, s2_adv;

  assign te_in = TW'(clamp_theta(32'(theta), WIDTH));

  for (genvar g = 0; g < WIDTH; g++) begin : gen_rows
    column_approx_row #(
      .WIDTH(WIDTH),
      .TW   (TW),
      .ROW  (g)
    ) u_row (
      .x_i    (x),
      .y_bit_i(y[g]),
      .te_i   (te_in),
      .row_o  (rows[g])
    );
  end

  always_comb begin
    sum_a = '0;
    sum_b = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i < SPLIT) sum_a = sum_a + rows[i];
      else           sum_b = sum_b + rows[i];
    end
  end

  // Ready depends only on valid registers and out_ready, never on in_valid.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      te_q       <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      a_q        <= sum_a;
      b_q        <= sum_b;
      te_q       <= te_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      z_q        <= '0;
      z_theta_q  <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      z_q        <= a_q + b_q;
      z_theta_q  <= te_q;
    end
  end

  assign out_valid = s2_valid_q;
  assign z         = z_q;
  assign z_theta   = z_theta_q;

endmodule
